// File: rtl/coherence_bus_arbiter.sv
// Shared-bus responder for a two-CPU MSI snooping system: captures per-CPU
// miss/upgrade requests, arbitrates round-robin, snoops the peer cache and answers.
module coherence_bus_arbiter #(
    parameter int ADDR_W         = 13,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            read_miss,
    input  logic [1:0]            write_miss,
    input  logic [1:0]            invalidate,
    input  logic [2*ADDR_W-1:0]   BICO,
    input  logic [1:0]            cpu_search_found,
    input  logic [3:0]            block_state,
    input  logic [2*DATA_W-1:0]   send_other_proc_data,
    input  logic                  mem_rdy,
    output logic [1:0]            grant,
    output logic [3:0]            cpu_datasel,
    output logic [1:0]            cpu_search,
    output logic [2*ADDR_W-1:0]   BOCI,
    output logic [1:0]            invalidate_from_other_cpu,
    output logic [2*DATA_W-1:0]   other_proc_data,
    output logic                  bus_busy,
    output logic                  bus_err,
    output logic [1:0]            dbg_state
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, SNOOP, RESP, MEM_WAIT} state_t;
    typedef enum logic [1:0] {REQ_READ, REQ_WRITE, REQ_INV} req_t;

    state_t             state, state_nx;
    logic [1:0]         pending;
    req_t               pend_type [2];
    logic [ADDR_W-1:0]  pend_addr [2];
    logic               owner, last_winner;
    req_t               cur_type;
    logic [ADDR_W-1:0]  cur_addr;
    logic               hit_o;
    logic [DATA_W-1:0]  snoop_data;
    logic [CNT_W-1:0]   wait_cnt;
    logic               other, win_valid, win_id, set_err;

    assign other     = ~owner;
    assign win_valid = |pending;
    // Lone requester wins outright; on a tie the CPU that did not win last time goes.
    assign win_id    = pending[1] & (~pending[0] | ~last_winner);
    assign bus_busy  = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        set_err  = 1'b0;
        case (state)
            IDLE:     if (win_valid) state_nx = SNOOP;
            SNOOP:    state_nx = RESP;
            RESP:     state_nx = (cur_type == REQ_READ && !hit_o) ? MEM_WAIT : IDLE;
            MEM_WAIT: begin
                if (mem_rdy) begin
                    state_nx = IDLE;
                end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nx = IDLE;
                    set_err  = 1'b1;
                end
            end
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= 2'b00;
            pend_type   <= '{REQ_READ, REQ_READ};
            pend_addr   <= '{'0, '0};
            owner       <= 1'b0;
            last_winner <= 1'b1;
            cur_type    <= REQ_READ;
            cur_addr    <= '0;
            hit_o       <= 1'b0;
            snoop_data  <= '0;
            wait_cnt    <= '0;
            bus_err     <= 1'b0;
        end else begin
            state <= state_nx;
            for (int i = 0; i < 2; i++) begin
                if (state == RESP && owner == 1'(i)) begin
                    pending[i] <= 1'b0;
                end else if ((read_miss[i] | write_miss[i] | invalidate[i]) &&
                             !(state != IDLE && owner == 1'(i))) begin
                    pending[i]   <= 1'b1;
                    pend_type[i] <= invalidate[i] ? REQ_INV :
                                    write_miss[i] ? REQ_WRITE : REQ_READ;
                    pend_addr[i] <= BICO[i*ADDR_W +: ADDR_W];
                end
            end
            if (state == IDLE && win_valid) begin
                owner       <= win_id;
                last_winner <= win_id;
                cur_type    <= pend_type[win_id];
                cur_addr    <= pend_addr[win_id];
            end
            if (state == SNOOP) begin
                hit_o      <= other ? (cpu_search_found[1] && block_state[3:2] != 2'b00)
                                    : (cpu_search_found[0] && block_state[1:0] != 2'b00);
                snoop_data <= other ? send_other_proc_data[2*DATA_W-1:DATA_W]
                                    : send_other_proc_data[DATA_W-1:0];
            end
            wait_cnt <= (state == MEM_WAIT && state_nx == MEM_WAIT) ? wait_cnt + 1'b1 : '0;
            if (set_err) bus_err <= 1'b1;
        end
    end

    always_comb begin
        grant                     = 2'b00;
        cpu_datasel               = 4'b0000;
        cpu_search                = 2'b00;
        BOCI                      = '0;
        invalidate_from_other_cpu = 2'b00;
        other_proc_data           = '0;
        case (state)
            SNOOP: begin
                cpu_search[other] = 1'b1;
                if (other) BOCI[2*ADDR_W-1:ADDR_W] = cur_addr;
                else       BOCI[ADDR_W-1:0]        = cur_addr;
            end
            RESP: begin
                grant[owner] = 1'b1;
                if (other) BOCI[2*ADDR_W-1:ADDR_W] = cur_addr;
                else       BOCI[ADDR_W-1:0]        = cur_addr;
                case (cur_type)
                    REQ_READ: begin
                        if (hit_o) begin
                            if (owner) begin
                                cpu_datasel[3:2]                   = 2'b01;
                                other_proc_data[2*DATA_W-1:DATA_W] = snoop_data;
                            end else begin
                                cpu_datasel[1:0]                   = 2'b01;
                                other_proc_data[DATA_W-1:0]        = snoop_data;
                            end
                        end
                    end
                    REQ_WRITE: invalidate_from_other_cpu[other] = hit_o;
                    REQ_INV:   invalidate_from_other_cpu[other] = 1'b1;
                    default:   ;
                endcase
            end
            MEM_WAIT: grant[owner] = 1'b1;
            default:  ;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter: stimulus pushes expected bus cycles,
// a negedge monitor pops and compares whenever the arbiter drives the bus.
module tb_coherence_bus_arbiter;
    localparam int W = 84;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  read_miss = '0, write_miss = '0, invalidate = '0;
    logic [25:0] BICO = '0;
    logic [1:0]  cpu_search_found = '0;
    logic [3:0]  block_state = '0;
    logic [31:0] send_other_proc_data = '0;
    logic        mem_rdy = 1'b0;
    logic [1:0]  grant, cpu_search, invalidate_from_other_cpu, dbg_state;
    logic [3:0]  cpu_datasel;
    logic [25:0] BOCI;
    logic [31:0] other_proc_data;
    logic        bus_busy, bus_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    coherence_bus_arbiter #(.ADDR_W(13), .DATA_W(16), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .read_miss(read_miss), .write_miss(write_miss),
        .invalidate(invalidate), .BICO(BICO), .cpu_search_found(cpu_search_found),
        .block_state(block_state), .send_other_proc_data(send_other_proc_data),
        .mem_rdy(mem_rdy), .grant(grant), .cpu_datasel(cpu_datasel),
        .cpu_search(cpu_search), .BOCI(BOCI),
        .invalidate_from_other_cpu(invalidate_from_other_cpu),
        .other_proc_data(other_proc_data), .bus_busy(bus_busy), .bus_err(bus_err),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [W-1:0] mk(input int c, input logic [1:0] g, input logic [3:0] ds,
                                        input logic [1:0] cs, input logic [25:0] bo,
                                        input logic [1:0] iv, input logic [31:0] od);
        logic [15:0] c16;
        c16 = c[15:0];
        return {c16, g, ds, cs, bo, iv, od};
    endfunction

    function automatic logic [25:0] bo_hi(input logic [12:0] a);
        return {a, 13'h0};
    endfunction

    function automatic logic [25:0] bo_lo(input logic [12:0] a);
        return {13'h0, a};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] act, expv;
        if (|grant || |cpu_search || |invalidate_from_other_cpu) begin
            act = {cyc[15:0], grant, cpu_datasel, cpu_search, BOCI,
                   invalidate_from_other_cpu, other_proc_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: got %h with nothing expected", act);
            end else begin
                expv = exp_q.pop_front();
                if (act !== expv) begin
                    errors++;
                    $display("FAIL bus_cycle: got %h expected %h", act, expv);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic set_snoop(input logic [1:0] f, input logic [3:0] bs, input logic [31:0] d);
        cpu_search_found     = f;
        block_state          = bs;
        send_other_proc_data = d;
    endtask

    task automatic pulse(input logic [1:0] rm, input logic [1:0] wm, input logic [1:0] iv,
                         input logic [12:0] a0, input logic [12:0] a1, output int n);
        @(posedge clk); #1;
        read_miss = rm; write_miss = wm; invalidate = iv; BICO = {a1, a0};
        n = cyc;
        @(posedge clk); #1;
        read_miss = '0; write_miss = '0; invalidate = '0; BICO = '0;
    endtask

    task automatic at_cycle(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((exp_q.size() != 0 || bus_busy) && guard < 100);
        if (guard >= 100) begin
            errors++;
            $display("FAIL idle_timeout: queue %0d busy %0d expected 0 0", exp_q.size(), bus_busy);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n, m;
        do_reset();
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_outs", {4'h0, cpu_datasel, BOCI}, 32'h0);
        check("reset_opd", other_proc_data, 32'h0);
        check("reset_busy_err", {bus_busy, bus_err, dbg_state}, 32'h0);

        // CPU0 read miss, peer misses, memory answers three cycles after RESP
        set_snoop(2'b00, 4'h0, 32'h0);
        pulse(2'b01, 2'b00, 2'b00, 13'h0104, 13'h0, n);
        exp_q.push_back(mk(n+2, 2'b00, 4'h0, 2'b10, bo_hi(13'h0104), 2'b00, 32'h0));
        exp_q.push_back(mk(n+3, 2'b01, 4'h0, 2'b00, bo_hi(13'h0104), 2'b00, 32'h0));
        for (int k = 4; k <= 6; k++) exp_q.push_back(mk(n+k, 2'b01, 4'h0, 2'b00, 26'h0, 2'b00, 32'h0));
        at_cycle(n+6);
        mem_rdy = 1'b1;
        @(posedge clk); #1 mem_rdy = 1'b0;
        check("t1_idle_after_mem", 32'(bus_busy), 32'h0);
        wait_idle();

        // CPU1 read miss, CPU0 holds MODIFIED copy
        set_snoop(2'b01, 4'b0010, 32'h0000_BEEF);
        pulse(2'b10, 2'b00, 2'b00, 13'h0, 13'h0040, n);
        exp_q.push_back(mk(n+2, 2'b00, 4'h0, 2'b01, bo_lo(13'h0040), 2'b00, 32'h0));
        exp_q.push_back(mk(n+3, 2'b10, 4'b0100, 2'b00, bo_lo(13'h0040), 2'b00, 32'hBEEF_0000));
        at_cycle(n+4);
        check("t2_idle_after_hit", 32'(bus_busy), 32'h0);
        wait_idle();

        // CPU0 invalidate, broadcast regardless of peer snoop
        set_snoop(2'b00, 4'h0, 32'h0);
        pulse(2'b00, 2'b00, 2'b01, 13'h0A03, 13'h0, n);
        exp_q.push_back(mk(n+2, 2'b00, 4'h0, 2'b10, bo_hi(13'h0A03), 2'b00, 32'h0));
        exp_q.push_back(mk(n+3, 2'b01, 4'h0, 2'b00, bo_hi(13'h0A03), 2'b10, 32'h0));
        wait_idle();

        // Tie after reset: CPU0 first, CPU1 SNOOP two cycles after CPU0 RESP
        do_reset();
        set_snoop(2'b11, 4'b0110, 32'h1234_5678);
        pulse(2'b11, 2'b00, 2'b00, 13'h0011, 13'h0022, n);
        exp_q.push_back(mk(n+2, 2'b00, 4'h0, 2'b10, bo_hi(13'h0011), 2'b00, 32'h0));
        exp_q.push_back(mk(n+3, 2'b01, 4'b0001, 2'b00, bo_hi(13'h0011), 2'b00, 32'h0000_1234));
        exp_q.push_back(mk(n+5, 2'b00, 4'h0, 2'b01, bo_lo(13'h0022), 2'b00, 32'h0));
        exp_q.push_back(mk(n+6, 2'b10, 4'b0100, 2'b00, bo_lo(13'h0022), 2'b00, 32'h5678_0000));
        wait_idle();
        // Lone CPU0 request makes CPU0 the last winner, so the next tie goes to CPU1
        pulse(2'b01, 2'b00, 2'b00, 13'h0033, 13'h0, n);
        exp_q.push_back(mk(n+2, 2'b00, 4'h0, 2'b10, bo_hi(13'h0033), 2'b00, 32'h0));
        exp_q.push_back(mk(n+3, 2'b01, 4'b0001, 2'b00, bo_hi(13'h0033), 2'b00, 32'h0000_1234));
        wait_idle();
        pulse(2'b11, 2'b00, 2'b00, 13'h0055, 13'h0044, m);
        exp_q.push_back(mk(m+2, 2'b00, 4'h0, 2'b01, bo_lo(13'h0044), 2'b00, 32'h0));
        exp_q.push_back(mk(m+3, 2'b10, 4'b0100, 2'b00, bo_lo(13'h0044), 2'b00, 32'h5678_0000));
        exp_q.push_back(mk(m+5, 2'b00, 4'h0, 2'b10, bo_hi(13'h0055), 2'b00, 32'h0));
        exp_q.push_back(mk(m+6, 2'b01, 4'b0001, 2'b00, bo_hi(13'h0055), 2'b00, 32'h0000_1234));
        wait_idle();

        // CPU1 write miss: peer SHARED -> invalidate; peer tag match but INVALID -> none
        set_snoop(2'b01, 4'b0001, 32'h0);
        pulse(2'b00, 2'b10, 2'b00, 13'h0, 13'h0100, n);
        exp_q.push_back(mk(n+2, 2'b00, 4'h0, 2'b01, bo_lo(13'h0100), 2'b00, 32'h0));
        exp_q.push_back(mk(n+3, 2'b10, 4'h0, 2'b00, bo_lo(13'h0100), 2'b01, 32'h0));
        wait_idle();
        set_snoop(2'b01, 4'b0000, 32'h0);
        pulse(2'b00, 2'b10, 2'b00, 13'h0, 13'h0101, n);
        exp_q.push_back(mk(n+2, 2'b00, 4'h0, 2'b01, bo_lo(13'h0101), 2'b00, 32'h0));
        exp_q.push_back(mk(n+3, 2'b10, 4'h0, 2'b00, bo_lo(13'h0101), 2'b00, 32'h0));
        wait_idle();

        // Timeout: memory never ready, eight MEM_WAIT cycles then sticky bus_err
        set_snoop(2'b00, 4'h0, 32'h0);
        check("err_before_timeout", 32'(bus_err), 32'h0);
        pulse(2'b01, 2'b00, 2'b00, 13'h1FFF, 13'h0, n);
        exp_q.push_back(mk(n+2, 2'b00, 4'h0, 2'b10, bo_hi(13'h1FFF), 2'b00, 32'h0));
        exp_q.push_back(mk(n+3, 2'b01, 4'h0, 2'b00, bo_hi(13'h1FFF), 2'b00, 32'h0));
        for (int k = 4; k <= 11; k++) exp_q.push_back(mk(n+k, 2'b01, 4'h0, 2'b00, 26'h0, 2'b00, 32'h0));
        at_cycle(n+11);
        check("err_not_yet", 32'(bus_err), 32'h0);
        at_cycle(n+12);
        check("err_after_timeout", {bus_err, bus_busy, grant}, {1'b1, 1'b0, 2'b00});
        wait_idle();

        // mem_rdy during RESP is ignored; only MEM_WAIT samples it
        pulse(2'b10, 2'b00, 2'b00, 13'h0, 13'h0007, n);
        exp_q.push_back(mk(n+2, 2'b00, 4'h0, 2'b01, bo_lo(13'h0007), 2'b00, 32'h0));
        exp_q.push_back(mk(n+3, 2'b10, 4'h0, 2'b00, bo_lo(13'h0007), 2'b00, 32'h0));
        exp_q.push_back(mk(n+4, 2'b10, 4'h0, 2'b00, 26'h0, 2'b00, 32'h0));
        exp_q.push_back(mk(n+5, 2'b10, 4'h0, 2'b00, 26'h0, 2'b00, 32'h0));
        at_cycle(n+3);
        mem_rdy = 1'b1;
        @(posedge clk); #1 mem_rdy = 1'b0;
        at_cycle(n+5);
        mem_rdy = 1'b1;
        @(posedge clk); #1 mem_rdy = 1'b0;
        wait_idle();
        check("err_sticky", 32'(bus_err), 32'h1);
        do_reset();
        check("err_cleared_by_rst", 32'(bus_err), 32'h0);

        // Reset mid-transaction drops the owner and a queued CPU1 request
        pulse(2'b01, 2'b00, 2'b00, 13'h0200, 13'h0, n);
        exp_q.push_back(mk(n+2, 2'b00, 4'h0, 2'b10, bo_hi(13'h0200), 2'b00, 32'h0));
        exp_q.push_back(mk(n+3, 2'b01, 4'h0, 2'b00, bo_hi(13'h0200), 2'b00, 32'h0));
        exp_q.push_back(mk(n+4, 2'b01, 4'h0, 2'b00, 26'h0, 2'b00, 32'h0));
        at_cycle(n+2);
        read_miss = 2'b10; BICO = {13'h0300, 13'h0};
        @(posedge clk); #1 read_miss = '0; BICO = '0;
        at_cycle(n+4);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst_mid_grant", {30'h0, grant}, 32'h0);
        check("rst_mid_busy", 32'(bus_busy), 32'h0);
        repeat (6) @(posedge clk);
        #1 check("rst_pending_lost", {29'h0, bus_busy, grant}, 32'h0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
